read_channel_axi: RTL and testbench
===================================

Name: read_channel_axi

Overview:
AXI4 read-side back-end channel of the cache. It is the line-fill counterpart of the single-word write channel.
On a replacement request it issues one INCR burst read for a whole cache line. It streams each returned beat into the cache data memory with a word index, and re-issues the burst if any beat returns an error response.
It sits between the cache replacement/control logic and the external AXI4 read address (AR) and read data (R) channels.

Parameters:
FE_ADDR_W, 32, front-end byte address width
FE_DATA_W, 32, front-end word width
BE_ADDR_W, FE_ADDR_W, AXI address width
BE_DATA_W, FE_DATA_W, AXI data width (>= FE_DATA_W)
BE_NBYTES, BE_DATA_W/8, bytes per AXI beat
BE_BYTE_W, $clog2(BE_NBYTES), byte-offset bits per beat
LINE2BE_W, 2, log2(beats per cache line), range 0..8
AXI_ID_W, 1, AXI ID width
AXI_ID, 0, constant ARID value

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  line-fill request
addr  in  FE_ADDR_W-BE_BYTE_W-LINE2BE_W  line address, bits [FE_ADDR_W-1:BE_BYTE_W+LINE2BE_W]
ready  out  1  high only in IDLE (channel free / fill complete)
mem_we  out  1  write enable to cache data memory
mem_word  out  max(1,LINE2BE_W)  beat index within line
mem_wdata  out  BE_DATA_W  beat data (= axi_rdata)
axi_arvalid  out  1  AR valid
axi_araddr  out  BE_ADDR_W  line-aligned byte address
axi_arlen  out  8  2**LINE2BE_W-1
axi_arsize  out  3  BE_BYTE_W
axi_arburst  out  2  2'b01 (INCR)
axi_arlock  out  1  0
axi_arcache  out  4  4'b0011
axi_arprot  out  3  0
axi_arqos  out  4  0
axi_arid  out  AXI_ID_W  AXI_ID
axi_arready  in  1  AR ready
axi_rvalid  in  1  R valid
axi_rdata  in  BE_DATA_W  R data
axi_rresp  in  2  R response
axi_rlast  in  1  last beat of burst
axi_rready  out  1  R ready

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it forces state IDLE, word counter 0 and error flag 0.
- Reset values of outputs:
  - ready=1.
  - axi_arvalid, axi_rready and mem_we are 0.
  - mem_word=0.
  - All constant outputs hold their fixed values.
- axi_araddr is combinational: {addr, (BE_BYTE_W+LINE2BE_W) zeros}, zero-extended to BE_ADDR_W. The requester holds addr stable while ready=0.
- The FSM has three states, with outputs decoded from state only (Moore):
  - IDLE: ready=1. If valid, go to ADDR and clear the counter and the error flag.
  - ADDR: axi_arvalid=1. On axi_arready go to READ, else stay. arvalid is never dropped before arready.
  - READ: axi_rready=1. Each accepted beat (rvalid & rready) does the following:
    - mem_we=1, combinational, in that same cycle.
    - mem_word = counter, mem_wdata = axi_rdata.
    - counter increments and wraps at 2**LINE2BE_W.
    - If rresp != 2'b00, the error flag sets.
    - On an accepted beat with rlast=1: if the error flag is set or this beat has rresp != 00, go to ADDR (full line refetch, counter cleared, flag cleared). Otherwise go to IDLE.
- Burst termination: the burst ends on rlast only; counter and rlast mismatches are not checked.
- Beats with an error response are still written to memory; the retry overwrites them.
- Latency: request to first AR is 1 cycle. Best-case fill is 1 (IDLE) + 1 (ADDR) + 2**LINE2BE_W (READ) cycles, after which ready=1.
- ready=1 means done: the requester must deassert valid in the first cycle ready returns high. Otherwise a new fill starts.
- LINE2BE_W=0: single beat, arlen=0, mem_word is 1 bit tied to 0.
- Reset mid-burst: immediate return to IDLE. Any remaining R beats are not accepted (rready=0). System reset is global, so the slave resets too.

Test Plan:
- LINE2BE_W=2, addr line 0x1000, arready immediate, 4 beats D0..D3 back-to-back with rresp=00 -> araddr=0x1000, arlen=3, arsize=2, arburst=01. mem_we pulses 4 cycles with mem_word 0,1,2,3 and data D0..D3. ready=1 six cycles after valid.
- arready delayed 5 cycles -> arvalid is held high for 6 cycles, araddr stays stable, no mem_we in that period.
- rvalid gapped (beats on cycles 0,2,3,6) -> mem_we only on those cycles, mem_word increments only on accepted beats.
- Beat 1 returns rresp=2'b10 -> all 4 beats still written. After rlast the FSM re-enters ADDR, issues a second AR with the same address, and a clean refill ends with ready=1.
- Reset asserted during beat 2 -> next cycle state is IDLE, ready=1, rready=0, arvalid=0, mem_we=0. A new request then starts at mem_word 0.
- LINE2BE_W=0 -> arlen=0, one beat with rlast=1 -> mem_word=0, ready=1 after 3 cycles.

Source files
------------

// File: rtl/read_channel_axi.sv
// AXI4 read-side line-fill channel: one INCR burst per cache line,
// each beat streamed into the data memory, full refetch on any error beat.
module read_channel_axi #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int BE_ADDR_W = FE_ADDR_W,
  parameter int BE_DATA_W = FE_DATA_W,
  parameter int BE_NBYTES = BE_DATA_W / 8,
  parameter int BE_BYTE_W = $clog2(BE_NBYTES),
  parameter int LINE2BE_W = 2,
  parameter int AXI_ID_W  = 1,
  parameter int AXI_ID    = 0,
  localparam int WORD_W   = (LINE2BE_W > 0) ? LINE2BE_W : 1,
  localparam int OFF_W    = BE_BYTE_W + LINE2BE_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid,
  input  logic [FE_ADDR_W-OFF_W-1:0]     addr,
  output logic                           ready,
  output logic                           mem_we,
  output logic [WORD_W-1:0]              mem_word,
  output logic [BE_DATA_W-1:0]           mem_wdata,
  output logic                           axi_arvalid,
  output logic [BE_ADDR_W-1:0]           axi_araddr,
  output logic [7:0]                     axi_arlen,
  output logic [2:0]                     axi_arsize,
  output logic [1:0]                     axi_arburst,
  output logic                           axi_arlock,
  output logic [3:0]                     axi_arcache,
  output logic [2:0]                     axi_arprot,
  output logic [3:0]                     axi_arqos,
  output logic [AXI_ID_W-1:0]            axi_arid,
  input  logic                           axi_arready,
  input  logic                           axi_rvalid,
  input  logic [BE_DATA_W-1:0]           axi_rdata,
  input  logic [1:0]                     axi_rresp,
  input  logic                           axi_rlast,
  output logic                           axi_rready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              beat;
  logic              bad;

  assign beat = (state_q == READ) && axi_rvalid;
  assign bad  = (axi_rresp != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = ADDR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ADDR: begin
        if (axi_arready) state_d = READ;
      end
      READ: begin
        if (beat) begin
          cnt_d = (LINE2BE_W == 0) ? '0 : cnt_q + 1'b1;
          err_d = err_q | bad;
          // a poisoned line is refetched in full, never patched
          if (axi_rlast) begin
            if (err_q || bad) begin
              state_d = ADDR;
              cnt_d   = '0;
              err_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign axi_arvalid = (state_q == ADDR);
  assign axi_rready  = (state_q == READ);
  assign mem_we      = beat;
  assign mem_word    = cnt_q;
  assign mem_wdata   = axi_rdata;

  assign axi_araddr  = BE_ADDR_W'({addr, {OFF_W{1'b0}}});
  assign axi_arlen   = 8'((1 << LINE2BE_W) - 1);
  assign axi_arsize  = 3'(BE_BYTE_W);
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0011;
  assign axi_arprot  = 3'b000;
  assign axi_arqos   = 4'b0000;
  assign axi_arid    = AXI_ID_W'(AXI_ID);

endmodule

// File: tb/tb_read_channel_axi.sv
// Bench for read_channel_axi: a randomized AXI slave drives line fills,
// beats are tracked per transaction and checked against the memory port.
module tb_read_channel_axi;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        valid, ready, mem_we;
  logic [27:0] addr;
  logic [1:0]  mem_word;
  logic [31:0] mem_wdata, araddr, rdata;
  logic        arvalid, arready, arlock, rvalid, rlast, rready;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache, arqos;
  logic [0:0]  arid;

  logic        z_valid, z_ready, z_mem_we;
  logic [29:0] z_addr;
  logic [0:0]  z_mem_word;
  logic [31:0] z_mem_wdata, z_araddr, z_rdata;
  logic        z_arvalid, z_arready, z_arlock, z_rvalid, z_rlast, z_rready;
  logic [7:0]  z_arlen;
  logic [2:0]  z_arsize, z_arprot;
  logic [1:0]  z_arburst, z_rresp;
  logic [3:0]  z_arcache, z_arqos;
  logic [0:0]  z_arid;

  read_channel_axi dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr),
    .ready(ready), .mem_we(mem_we), .mem_word(mem_word),
    .mem_wdata(mem_wdata), .axi_arvalid(arvalid),
    .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
    .axi_arburst(arburst), .axi_arlock(arlock),
    .axi_arcache(arcache), .axi_arprot(arprot), .axi_arqos(arqos),
    .axi_arid(arid), .axi_arready(arready), .axi_rvalid(rvalid),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
    .axi_rready(rready)
  );

  read_channel_axi #(.LINE2BE_W(0)) dut0 (
    .clk(clk), .reset(reset), .valid(z_valid), .addr(z_addr),
    .ready(z_ready), .mem_we(z_mem_we), .mem_word(z_mem_word),
    .mem_wdata(z_mem_wdata), .axi_arvalid(z_arvalid),
    .axi_araddr(z_araddr), .axi_arlen(z_arlen),
    .axi_arsize(z_arsize), .axi_arburst(z_arburst),
    .axi_arlock(z_arlock), .axi_arcache(z_arcache),
    .axi_arprot(z_arprot), .axi_arqos(z_arqos), .axi_arid(z_arid),
    .axi_arready(z_arready), .axi_rvalid(z_rvalid),
    .axi_rdata(z_rdata), .axi_rresp(z_rresp), .axi_rlast(z_rlast),
    .axi_rready(z_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One line fill as seen by the requester and an AXI slave. Expected
  // beat index is the count of beats this slave has handed over.
  task automatic fill(input logic [27:0] a, input int ar_dly,
                      input int gap_pct, input int err_beat,
                      output int cyc);
    int  att;
    int  b;
    int  tries;
    bit  again;
    cyc = 0;
    @(negedge clk);
    chk("idle_ready", ready, 1);
    valid = 1'b1;
    addr  = a;
    @(posedge clk);
    cyc++;
    att   = 0;
    again = 1'b1;
    while (again && att < 3) begin
      again = 1'b0;
      for (int k = 0; k <= ar_dly; k++) begin
        @(negedge clk);
        valid   = 1'b0;
        rvalid  = 1'($urandom);
        rlast   = 1'b0;
        arready = (k == ar_dly);
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, {a, 4'h0});
        chk("ar_we", mem_we, 0);
        chk("ar_rready", rready, 0);
        chk("ar_ready", ready, 0);
        @(posedge clk);
        cyc++;
      end
      b     = 0;
      tries = 0;
      while (b < NB) begin
        @(negedge clk);
        arready = 1'b0;
        rvalid  = (tries >= 8) || ($urandom_range(99) >= gap_pct);
        rdata   = $urandom;
        rresp   = (att == 0 && b == err_beat) ? 2'b10 : 2'b00;
        rlast   = (b == NB - 1);
        #1;
        chk("rready", rready, 1);
        chk("we", mem_we, rvalid);
        if (rvalid) begin
          chk("word", mem_word, 64'(b));
          chk("wdata", mem_wdata, rdata);
          if (rresp != 2'b00) again = 1'b1;
          b++;
          tries = 0;
        end else begin
          tries++;
        end
        @(posedge clk);
        cyc++;
      end
      att++;
    end
    @(negedge clk);
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    #1;
    chk("done_ready", ready, 1);
    chk("done_rready", rready, 0);
    chk("done_arvalid", arvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    valid = 0; addr = '0; arready = 0; rvalid = 0;
    rdata = '0; rresp = '0; rlast = 0;
    z_valid = 0; z_addr = '0; z_arready = 0; z_rvalid = 0;
    z_rdata = '0; z_rresp = '0; z_rlast = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_word", mem_word, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("arlen", arlen, 3);
    chk("arsize", arsize, 2);
    chk("arburst", arburst, 1);
    chk("arcache", arcache, 3);
    chk("arlock", arlock, 0);
    chk("arprot", arprot, 0);
    chk("arqos", arqos, 0);
    chk("arid", arid, 0);

    fill(28'h0000100, 0, 0, -1, cyc);
    chk("latency", cyc, 6);
    fill(28'h0000100, 5, 0, -1, cyc);
    chk("latency_ar5", cyc, 11);
    fill(28'h0abcdef, 0, 50, -1, cyc);
    fill(28'h0000100, 0, 0, 1, cyc);
    chk("latency_retry", cyc, 11);
    fill(28'h0000200, 1, 0, 3, cyc);

    // reset with beat 2 on the bus
    @(negedge clk);
    valid = 1'b1;
    addr  = 28'h0000300;
    @(posedge clk);
    @(negedge clk);
    valid   = 1'b0;
    arready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b1;
      rdata   = $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_word", mem_word, 0);
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    rvalid = 1'b0;
    fill(28'h0000300, 0, 0, -1, cyc);

    for (int n = 0; n < 25; n++) begin
      fill(28'($urandom), $urandom_range(4), $urandom_range(60),
           int'($urandom_range(7)) - 4 < 0 ? -1 : int'($urandom_range(3)),
           cyc);
    end

    // single-beat line instance
    @(negedge clk);
    chk("z_ready0", z_ready, 1);
    chk("z_arlen", z_arlen, 0);
    chk("z_word0", z_mem_word, 0);
    z_valid = 1'b1;
    z_addr  = 30'h1234567;
    @(posedge clk);
    @(negedge clk);
    z_valid = 1'b0;
    chk("z_arvalid", z_arvalid, 1);
    chk("z_araddr", z_araddr, 32'h048d159c);
    z_arready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    z_arready = 1'b0;
    z_rvalid  = 1'b1;
    z_rlast   = 1'b1;
    z_rdata   = 32'hcafef00d;
    #1;
    chk("z_we", z_mem_we, 1);
    chk("z_word", z_mem_word, 0);
    chk("z_wdata", z_mem_wdata, 32'hcafef00d);
    @(posedge clk);
    @(negedge clk);
    z_rvalid = 1'b0;
    z_rlast  = 1'b0;
    chk("z_done", z_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
